// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared types and default sizes for the counter reload path.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_LCW   = 8;

    typedef logic [DEF_WIDTH-1:0] count_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOAD    = 2'd1,
        S_RUN     = 2'd2,
        S_STARVED = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, registered pointers, no write-to-read bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_data,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_level
);

    localparam int c_aw = $clog2(DEPTH);
    localparam logic [c_aw:0] c_depth = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw:0]    r_wr_ptr;
    logic [c_aw:0]    r_rd_ptr;
    logic [c_aw:0]    w_level;
    logic             w_do_push;
    logic             w_do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign w_level   = r_wr_ptr - r_rd_ptr;
    assign o_level   = w_level;
    assign o_full    = (w_level == c_depth);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;
    assign o_data    = r_mem[r_rd_ptr[c_aw-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + (c_aw+1)'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + (c_aw+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr[c_aw-1:0]] <= i_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/counter_loader.sv
`default_nettype none
// ============================================================================
// Module      : counter_loader
// Description : Reload sequencer: buffers load values, one load per tc event.
// Revision    : 1.0 - initial release
// ============================================================================
module counter_loader
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LCW   = DEF_LCW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       tc,
    input  logic [WIDTH-1:0]           count,
    output logic                       ld_enb,
    output logic [WIDTH-1:0]           ld_data,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       underrun,
    output logic [LCW-1:0]             load_count
);

    state_t           r_state;
    logic             r_ld_enb;
    logic [WIDTH-1:0] r_ld_data;
    logic             r_underrun;
    logic [LCW-1:0]   r_load_count;

    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [WIDTH-1:0] w_fifo_data;
    logic             w_pop;

    // The wrap of count while starved needs no action; it is observed only.
    logic w_unused_count;
    assign w_unused_count = &count;

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (fifo_level)
    );

    assign in_ready = !w_fifo_full;

    // tc is only honoured in S_RUN; S_LOAD never pops, so loads cannot be back to back.
    always_comb begin
        w_pop = 1'b0;
        case (r_state)
            S_IDLE:    w_pop = !w_fifo_empty;
            S_RUN:     w_pop = tc && !w_fifo_empty;
            S_STARVED: w_pop = !w_fifo_empty;
            default:   w_pop = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ld_enb     <= 1'b0;
            r_ld_data    <= '0;
            r_underrun   <= 1'b0;
            r_load_count <= '0;
        end else begin
            r_ld_enb <= 1'b0;
            if (w_pop) begin
                r_state      <= S_LOAD;
                r_ld_enb     <= 1'b1;
                r_ld_data    <= w_fifo_data;
                r_load_count <= r_load_count + LCW'(1);
            end else begin
                case (r_state)
                    S_LOAD: r_state <= S_RUN;
                    S_RUN: begin
                        if (tc) begin
                            r_underrun <= 1'b1;
                            r_state    <= S_STARVED;
                        end
                    end
                    default: r_state <= r_state;
                endcase
            end
        end
    end

    assign ld_enb     = r_ld_enb;
    assign ld_data    = r_ld_data;
    assign underrun   = r_underrun;
    assign load_count = r_load_count;

endmodule
`default_nettype wire
